// File: rtl/uart_rx_if.sv
`timescale 1ns/1ps
// Byte stream from the UART receiver FIFO to its consumer.
// master drives data_o/valid_o and samples ready_i; slave is the consumer side.
interface uart_rx_if;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;

    modport master (output data_o, output valid_o, input  ready_i);
    modport slave  (input  data_o, input  valid_o, output ready_i);
endinterface

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// UART receiver: 2-flop synced rx line, 8N1 deframer (8E1 when UART_RX_PARITY_EN), FIFO to a valid/ready stream.
// Latency: byte pushed mid-stop-bit, valid_o one cycle later; line-to-decision is 2 cycles through the synchronizer.
// Backpressure: stream waits on ready_i; a good byte arriving at a full FIFO is dropped with an overrun_o pulse.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_i,
    uart_rx_if.master   rx_stream,
    output logic        busy_o,
    output logic        frame_err_o,
    output logic        overrun_o,
    output logic        parity_err_o
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    logic          r_sync1, r_sync2;
    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]    r_bit_idx, w_idx_nxt;
    logic [7:0]    r_shreg, w_shreg_nxt;
    logic          w_rx_s, w_cnt_last, w_stop_ok, w_frame_err, w_good, w_par_err;
`ifdef UART_RX_PARITY_EN
    logic          r_par, w_par_nxt;
`endif

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW:0]   r_wr_ptr, r_rd_ptr, w_wr_nxt, w_rd_nxt;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          w_full, w_push, w_pop, w_overrun;

    assign w_rx_s     = r_sync2;
    assign w_cnt_last = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shreg   <= '0;
`ifdef UART_RX_PARITY_EN
            r_par     <= 1'b0;
`endif
        end else begin
            r_sync1   <= rx_i;
            r_sync2   <= r_sync1;
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_idx_nxt;
            r_shreg   <= w_shreg_nxt;
`ifdef UART_RX_PARITY_EN
            r_par     <= w_par_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_idx_nxt   = r_bit_idx;
        w_shreg_nxt = r_shreg;
        w_stop_ok   = 1'b0;
        w_frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_nxt   = r_par;
`endif
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (!w_rx_s) w_state_nxt = S_START;
            end
            S_START: begin
                // Mid start bit: a line that is high again was only a glitch.
                if (r_cnt == HALF_LAST) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_cnt_last) begin
                    w_cnt_nxt   = '0;
                    w_shreg_nxt = {w_rx_s, r_shreg[7:1]};
                    w_idx_nxt   = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end
            end
            S_PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (w_cnt_last) begin
                    w_cnt_nxt   = '0;
                    w_par_nxt   = w_rx_s;
                    w_state_nxt = S_STOP;
                end
`else
                w_state_nxt = S_IDLE;
`endif
            end
            S_STOP: begin
                if (w_cnt_last) begin
                    w_cnt_nxt = '0;
                    if (w_rx_s) begin
                        w_stop_ok   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_frame_err = 1'b1;
                        w_state_nxt = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                w_cnt_nxt = '0;
                if (w_rx_s) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    assign w_par_err = w_stop_ok & (^{r_shreg, r_par});
`else
    assign w_par_err = 1'b0;
`endif
    assign w_good = w_stop_ok & ~w_par_err;

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_pop     = r_valid & rx_stream.ready_i;
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push    = w_good & (~w_full | w_pop);
    assign w_overrun = w_good & w_full & ~w_pop;
    assign w_wr_nxt  = r_wr_ptr + {{AW{1'b0}}, w_push};
    assign w_rd_nxt  = r_rd_ptr + {{AW{1'b0}}, w_pop};

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= r_shreg;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
            r_valid  <= (w_wr_nxt != w_rd_nxt);
            // Bypass the byte being written when it becomes the new head.
            if (w_push && (r_wr_ptr[AW-1:0] == w_rd_nxt[AW-1:0]))
                r_data <= r_shreg;
            else
                r_data <= r_mem[w_rd_nxt[AW-1:0]];
        end
    end

    assign rx_stream.data_o  = r_data;
    assign rx_stream.valid_o = r_valid;
    assign busy_o            = (r_state != S_IDLE);
    assign frame_err_o       = w_frame_err;
    assign overrun_o         = w_overrun;
    assign parity_err_o      = w_par_err;
endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// Bench for uart_rx: serial frames built from the framing rules, results checked against expected byte queues and flag counts.
module tb_uart_rx;
    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx_i = 1'b1;
    logic ready = 1'b0;
    logic busy_o, frame_err_o, overrun_o, parity_err_o;

    uart_rx_if u_if();
    assign u_if.ready_i = ready;

    uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_i         (rx_i),
        .rx_stream    (u_if),
        .busy_o       (busy_o),
        .frame_err_o  (frame_err_o),
        .overrun_o    (overrun_o),
        .parity_err_o (parity_err_o)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    logic [7:0] got[$];
    int n_fe = 0, n_ov = 0, n_pe = 0;

    // Observer: every accepted byte and every pulse cycle is recorded.
    always @(negedge clk) begin
        if (rst) begin
            if (u_if.valid_o && u_if.ready_i) got.push_back(u_if.data_o);
            if (frame_err_o)  n_fe++;
            if (overrun_o)    n_ov++;
            if (parity_err_o) n_pe++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Start bit, 8 data bits LSB first, optional even parity, stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input logic bad_par, input logic pulse_rdy);
        rx_i = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            tick(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rx_i = (^b) ^ bad_par;
        tick(CPB);
`endif
        rx_i = stop_bit;
        if (pulse_rdy) begin
            tick(CPB / 2 + 2);
            ready = 1'b1;
            tick(1);
            ready = 1'b0;
            tick(CPB / 2 - 3);
        end else begin
            tick(CPB);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; rx_i = 1'b1; ready = 1'b0;
        tick(3);
        vectors++; if (u_if.valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", u_if.valid_o); end
        vectors++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        vectors++; if (u_if.data_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", u_if.data_o); end
        vectors++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", frame_err_o); end
        vectors++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b expected 0", overrun_o); end
        vectors++; if (parity_err_o !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b expected 0", parity_err_o); end
        rst = 1'b1;
        tick(5);
    endtask

    task automatic test_basic();
        int g0, fe0, ov0, pe0;
        ready = 1'b1;
        g0 = got.size(); fe0 = n_fe; ov0 = n_ov; pe0 = n_pe;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        vectors++; if (busy_o !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b expected 0", busy_o); end
        rx_i = 1'b1;
        tick(4);
        vectors++; if (got.size() - g0 != 1) begin errors++; $display("FAIL basic_count: got %0d expected 1", got.size() - g0); end
        else begin
            vectors++; if (got[g0] !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h expected a5", got[g0]); end
        end
        vectors++; if (n_fe + n_ov + n_pe - fe0 - ov0 - pe0 != 0) begin errors++; $display("FAIL basic_flags: got %0d expected 0", n_fe + n_ov + n_pe - fe0 - ov0 - pe0); end
        vectors++; if (u_if.valid_o !== 1'b0) begin errors++; $display("FAIL basic_valid_after: got %b expected 0", u_if.valid_o); end
    endtask

    task automatic test_glitch();
        int g0, fe0, ov0, pe0;
        ready = 1'b1;
        g0 = got.size(); fe0 = n_fe; ov0 = n_ov; pe0 = n_pe;
        rx_i = 1'b0;
        tick(5);
        rx_i = 1'b1;
        vectors++; if (busy_o !== 1'b1) begin errors++; $display("FAIL glitch_busy_seen: got %b expected 1", busy_o); end
        tick(8);
        vectors++; if (busy_o !== 1'b0) begin errors++; $display("FAIL glitch_busy_clear: got %b expected 0", busy_o); end
        tick(4 * CPB);
        vectors++; if (got.size() != g0) begin errors++; $display("FAIL glitch_bytes: got %0d expected 0", got.size() - g0); end
        vectors++; if (n_fe + n_ov + n_pe - fe0 - ov0 - pe0 != 0) begin errors++; $display("FAIL glitch_flags: got %0d expected 0", n_fe + n_ov + n_pe - fe0 - ov0 - pe0); end
    endtask

    task automatic test_overrun();
        int g0, fe0, ov0;
        ready = 1'b0;
        g0 = got.size(); fe0 = n_fe; ov0 = n_ov;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0);
        rx_i = 1'b1;
        tick(4);
        vectors++; if (n_ov - ov0 != 1) begin errors++; $display("FAIL ovr_pulses: got %0d expected 1", n_ov - ov0); end
        vectors++; if (n_fe - fe0 != 0) begin errors++; $display("FAIL ovr_ferr: got %0d expected 0", n_fe - fe0); end
        vectors++; if (got.size() != g0) begin errors++; $display("FAIL ovr_early_pop: got %0d expected 0", got.size() - g0); end
        vectors++; if (u_if.valid_o !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b expected 1", u_if.valid_o); end
        vectors++; if (u_if.data_o !== 8'h01) begin errors++; $display("FAIL ovr_head: got %h expected 01", u_if.data_o); end
        ready = 1'b1;
        tick(10);
        vectors++; if (got.size() - g0 != 4) begin errors++; $display("FAIL ovr_drain_count: got %0d expected 4", got.size() - g0); end
        else for (int i = 0; i < 4; i++) begin
            vectors++; if (got[g0 + i] !== 8'(i + 1)) begin errors++; $display("FAIL ovr_drain_%0d: got %h expected %h", i, got[g0 + i], 8'(i + 1)); end
        end
        vectors++; if (u_if.valid_o !== 1'b0) begin errors++; $display("FAIL ovr_empty: got %b expected 0", u_if.valid_o); end
    endtask

    task automatic test_break();
        int g0, fe0, ov0, pe0;
        ready = 1'b1;
        g0 = got.size(); fe0 = n_fe; ov0 = n_ov; pe0 = n_pe;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        tick(40 * CPB);
        rx_i = 1'b1;
        tick(2 * CPB);
        vectors++; if (got.size() != g0) begin errors++; $display("FAIL break_push: got %0d expected 0", got.size() - g0); end
        send_frame(8'h7E, 1'b1, 1'b0, 1'b0);
        rx_i = 1'b1;
        tick(CPB);
        vectors++; if (n_fe - fe0 != 1) begin errors++; $display("FAIL break_ferr: got %0d expected 1", n_fe - fe0); end
        vectors++; if (n_ov + n_pe - ov0 - pe0 != 0) begin errors++; $display("FAIL break_other: got %0d expected 0", n_ov + n_pe - ov0 - pe0); end
        vectors++; if (got.size() - g0 != 1) begin errors++; $display("FAIL break_after_count: got %0d expected 1", got.size() - g0); end
        else begin
            vectors++; if (got[g0] !== 8'h7E) begin errors++; $display("FAIL break_after_data: got %h expected 7e", got[g0]); end
        end
    endtask

    task automatic test_full_push_pop();
        int g0, ov0;
        logic [7:0] b[5];
        for (int i = 0; i < 5; i++) b[i] = 8'($urandom_range(0, 255));
        ready = 1'b0;
        g0 = got.size(); ov0 = n_ov;
        for (int i = 0; i < 4; i++) send_frame(b[i], 1'b1, 1'b0, 1'b0);
        send_frame(b[4], 1'b1, 1'b0, 1'b1);
        rx_i = 1'b1;
        tick(4);
        vectors++; if (n_ov - ov0 != 0) begin errors++; $display("FAIL pp_overrun: got %0d expected 0", n_ov - ov0); end
        vectors++; if (got.size() - g0 != 1) begin errors++; $display("FAIL pp_pulse_pop: got %0d expected 1", got.size() - g0); end
        ready = 1'b1;
        tick(10);
        vectors++; if (got.size() - g0 != 5) begin errors++; $display("FAIL pp_drain_count: got %0d expected 5", got.size() - g0); end
        else for (int i = 0; i < 5; i++) begin
            vectors++; if (got[g0 + i] !== b[i]) begin errors++; $display("FAIL pp_drain_%0d: got %h expected %h", i, got[g0 + i], b[i]); end
        end
    endtask

    // Random bytes, gaps, bad stop bits and bad parity against a queue-based model.
    task automatic test_random_stream();
        int g0, fe0, ov0, pe0, exp_fe, exp_pe;
        logic [7:0] exp_q[$];
        logic [7:0] d;
        logic stop_bit, bad_par;
        ready = 1'b1;
        g0 = got.size(); fe0 = n_fe; ov0 = n_ov; pe0 = n_pe;
        exp_fe = 0; exp_pe = 0;
        for (int n = 0; n < 16; n++) begin
            d        = 8'($urandom_range(0, 255));
            stop_bit = ($urandom_range(0, 4) != 0);
`ifdef UART_RX_PARITY_EN
            bad_par  = ($urandom_range(0, 4) == 0);
`else
            bad_par  = 1'b0;
`endif
            send_frame(d, stop_bit, bad_par, 1'b0);
            if (!stop_bit) exp_fe++;
            else if (bad_par) exp_pe++;
            else exp_q.push_back(d);
            rx_i = 1'b1;
            tick(stop_bit ? $urandom_range(0, 20) : $urandom_range(4, 20));
        end
        tick(CPB);
        vectors++; if (n_fe - fe0 != exp_fe) begin errors++; $display("FAIL rnd_ferr: got %0d expected %0d", n_fe - fe0, exp_fe); end
        vectors++; if (n_pe - pe0 != exp_pe) begin errors++; $display("FAIL rnd_perr: got %0d expected %0d", n_pe - pe0, exp_pe); end
        vectors++; if (n_ov - ov0 != 0) begin errors++; $display("FAIL rnd_ovr: got %0d expected 0", n_ov - ov0); end
        vectors++; if (got.size() - g0 != exp_q.size()) begin errors++; $display("FAIL rnd_count: got %0d expected %0d", got.size() - g0, exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            vectors++; if (got[g0 + i] !== exp_q[i]) begin errors++; $display("FAIL rnd_byte_%0d: got %h expected %h", i, got[g0 + i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_midframe();
        int g0, fe0, ov0, pe0;
        logic [7:0] a, c;
        a = 8'($urandom_range(0, 255));
        c = 8'($urandom_range(0, 255));
        ready = 1'b0;
        send_frame(a, 1'b1, 1'b0, 1'b0);
        rx_i = 1'b1;
        tick(4);
        vectors++; if (u_if.valid_o !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid: got %b expected 1", u_if.valid_o); end
        rx_i = 1'b0; tick(CPB);
        rx_i = c[0]; tick(CPB);
        rx_i = c[1]; tick(CPB / 2);
        rst = 1'b0;
        #1;
        vectors++; if (u_if.valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", u_if.valid_o); end
        vectors++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy_o); end
        vectors++; if (u_if.data_o !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h expected 00", u_if.data_o); end
        rx_i = 1'b1;
        tick(3);
        rst = 1'b1;
        tick(5);
        g0 = got.size(); fe0 = n_fe; ov0 = n_ov; pe0 = n_pe;
        ready = 1'b1;
        send_frame(c, 1'b1, 1'b0, 1'b0);
        rx_i = 1'b1;
        tick(CPB);
        vectors++; if (got.size() - g0 != 1) begin errors++; $display("FAIL rstmid_count: got %0d expected 1", got.size() - g0); end
        else begin
            vectors++; if (got[g0] !== c) begin errors++; $display("FAIL rstmid_byte: got %h expected %h", got[g0], c); end
        end
        vectors++; if (n_fe + n_ov + n_pe - fe0 - ov0 - pe0 != 0) begin errors++; $display("FAIL rstmid_flags: got %0d expected 0", n_fe + n_ov + n_pe - fe0 - ov0 - pe0); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int g0, fe0, pe0;
        ready = 1'b1;
        g0 = got.size(); fe0 = n_fe; pe0 = n_pe;
        send_frame(8'h03, 1'b1, 1'b0, 1'b0);
        send_frame(8'h03, 1'b1, 1'b1, 1'b0);
        rx_i = 1'b1;
        tick(CPB);
        vectors++; if (n_pe - pe0 != 1) begin errors++; $display("FAIL par_pulses: got %0d expected 1", n_pe - pe0); end
        vectors++; if (n_fe - fe0 != 0) begin errors++; $display("FAIL par_ferr: got %0d expected 0", n_fe - fe0); end
        vectors++; if (got.size() - g0 != 1) begin errors++; $display("FAIL par_count: got %0d expected 1", got.size() - g0); end
        else begin
            vectors++; if (got[g0] !== 8'h03) begin errors++; $display("FAIL par_data: got %h expected 03", got[g0]); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_overrun();
        test_break();
        test_full_push_pop();
        test_random_stream();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial UART receiver for the SoC console path. It is the input counterpart of the transmitter inside uart_wrapper.
- Samples the asynchronous rx line and deframes 8N1 characters (8E1 with the optional feature).
- Buffers received bytes in a small FIFO.
- Delivers bytes through a valid/ready stream that uart_wrapper maps onto its MemPort register window.

Parameters:
CLKS_PER_BIT, 868, clk cycles per bit period (100 MHz / 115200); minimum 4.
FIFO_DEPTH, 4, receive FIFO entries; power of two, minimum 2.

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low
rx_i  input  1  serial line, asynchronous to clk, idle high
data_o  output  8  head-of-FIFO byte; valid only while valid_o=1
valid_o  output  1  FIFO non-empty
ready_i  input  1  consumer accepts data_o when valid_o&&ready_i
busy_o  output  1  deframer not in IDLE
frame_err_o  output  1  one-cycle pulse: stop bit sampled 0
overrun_o  output  1  one-cycle pulse: good byte dropped, FIFO full
parity_err_o  output  1  one-cycle pulse: parity mismatch (tied 0 without feature)

Behaviour:
- Reset (rst=0, async): state IDLE, counters 0, FIFO empty.
  - Outputs: valid_o=0, busy_o=0, data_o=0, all error pulses 0.
  - Synchronizer flops preset to 1.
- rx_i passes through a 2-flop synchronizer (rx_s). All decisions use rx_s, so line-to-decision latency is 2 cycles.
- Bit counter cnt counts 0..CLKS_PER_BIT-1.
- IDLE: on rx_s=0 → START, cnt=0.
- START: at cnt=CLKS_PER_BIT/2-1 (integer divide), sample rx_s.
  - 1 → false start, back to IDLE, no flags.
  - 0 → cnt=0, bit index=0, go DATA.
- DATA: at each cnt=CLKS_PER_BIT-1, shift rx_s into the shift register, LSB first. After 8 samples → STOP (or PARITY with the feature).
- STOP: at cnt=CLKS_PER_BIT-1, sample rx_s.
  - 1, FIFO not full → push byte that same cycle; state IDLE.
  - 1, FIFO full → discard byte, pulse overrun_o; state IDLE.
  - 0 → discard byte, pulse frame_err_o; state BREAK.
- BREAK: wait for rx_s=1, then IDLE. A held-low line (break) produces exactly one frame_err_o.
- Sampling is mid-bit. A frame is accepted CLKS_PER_BIT/2 cycles before the nominal end of the stop bit, so back-to-back frames are received without loss.
- busy_o=1 in every state except IDLE.
- FIFO:
  - Write pointer and read pointer are log2(FIFO_DEPTH)+1 bits wide and wrap naturally.
  - full = MSBs differ and lower bits equal.
  - empty = pointers equal.
  - data_o is registered from mem[rd_ptr]. valid_o rises 1 cycle after the push cycle.
  - Pop on valid_o&&ready_i. data_o/valid_o reflect the next entry on the following cycle.
  - Simultaneous push and pop while full: pop frees the slot first, push succeeds, no overrun.
  - Simultaneous push and pop while empty: push lands; valid_o next cycle.
- ready_i is ignored while valid_o=0.
- data_o holds stable while valid_o=1 and ready_i=0.
- Reset mid-frame: partial byte discarded, FIFO cleared, no error pulses.

Optional Feature:
UART_RX_PARITY_EN
- Defined:
  - Frame is 8E1. After the 8th data bit the FSM enters PARITY.
  - PARITY samples at cnt=CLKS_PER_BIT-1, then goes to STOP.
  - If the XOR of the data bits and the parity bit is 1 → parity_err_o pulses in the STOP decision cycle and the byte is discarded.
  - A framing error takes precedence: frame_err_o only.
- Not defined:
  - No PARITY state; frame is 8N1.
  - parity_err_o is constant 0.

Test Plan:
- CLKS_PER_BIT=16, FIFO_DEPTH=4. Send 0xA5 8N1 with ready_i=1 → valid_o for one cycle with data_o=0xA5; no error pulses; busy_o low after the stop-bit sample.
- Glitch: rx_i low for 5 cycles then high → no byte, no flags, busy_o returns to 0 within 8 cycles.
- ready_i=0, send 0x01,0x02,0x03,0x04,0x05 back-to-back → one overrun_o pulse, on the 5th stop-bit cycle. Then ready_i=1 → pops 0x01..0x04 in order, then valid_o=0.
- Send 0x3C with stop bit forced 0, then line held low for 40 bits → exactly one frame_err_o, no push. After release, send 0x7E → received correctly.
- FIFO full and ready_i pulsed in the same cycle as the 5th byte's push → no overrun; all 5 bytes drain in order.
- With UART_RX_PARITY_EN:
  - Send 0x03 with parity 0 → accepted.
  - Send 0x03 with parity 1 → one parity_err_o pulse, no push.
  - Assert rst mid-data-bit → valid_o=0 immediately, and the next clean frame is received correctly.
